alu_issue_stage: RTL and testbench

- Decodes RV32I ALU-class instructions into ALU select codes and registers the operands that drive the 32-bit ALU (in1, in2, aluSel).
- Sits between the decode/register-read stage and the combinational ALU, acting as the initiator side of the ALU operand interface.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so that full throughput is sustained under backpressure.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_op_decode.sv | 88 ++++++++
 rtl/alu_issue_stage.sv | 104 ++++++++++
 tb/tb_alu_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: select codes, opcodes
// and the packed issue entry carried by the skid buffer.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [3:0]        sel;
    logic              is_branch;
    logic              branch_ne;
    logic              illegal;
  } issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I ALU-class decoder.
// Ports: instr in; sel, use_imm, is_branch, branch_ne, illegal out.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  sel,
  output logic        use_imm,
  output logic        is_branch,
  output logic        branch_ne,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       is_r;
  logic       is_i;
  logic       is_br;
  logic       is_ls;
  logic       unused;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7b5   = instr[30];
  assign is_r   = opcode == OP_R;
  assign is_i   = opcode == OP_I;
  assign is_br  = opcode == OP_BR;
  assign is_ls  = (opcode == OP_LD) || (opcode == OP_ST);
  assign unused = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    sel       = ALU_AND;
    use_imm   = 1'b0;
    is_branch = 1'b0;
    branch_ne = 1'b0;
    illegal   = 1'b1;
    unique case (1'b1)
      is_r: begin
        if (f3 == 3'b000) begin
          sel     = f7b5 ? ALU_SUB : ALU_ADD;
          illegal = 1'b0;
        end else if (f3 == 3'b111) begin
          sel     = ALU_AND;
          illegal = 1'b0;
        end else if (f3 == 3'b110) begin
          sel     = ALU_OR;
          illegal = 1'b0;
        end
      end
      is_i: begin
        use_imm = 1'b1;
        if (f3 == 3'b000) begin
          sel     = ALU_ADD;
          illegal = 1'b0;
        end else if (f3 == 3'b111) begin
          sel     = ALU_AND;
          illegal = 1'b0;
        end else if (f3 == 3'b110) begin
          sel     = ALU_OR;
          illegal = 1'b0;
        end
      end
      is_br: begin
        if (f3[2:1] == 2'b00) begin
          sel       = ALU_SUB;
          is_branch = 1'b1;
          branch_ne = f3[0];
          illegal   = 1'b0;
        end
      end
      is_ls: begin
        sel     = ALU_ADD;
        use_imm = 1'b1;
        illegal = 1'b0;
      end
      default: ;
    endcase
    // Illegal encodings never leak a partial decode.
    if (illegal) begin
      sel       = ALU_AND;
      use_imm   = 1'b0;
      is_branch = 1'b0;
      branch_ne = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes, builds operands, 2-entry skid buffer.
// Ports: s_* upstream handshake + operands, m_*/alu_* downstream, illegal_cnt.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [XLEN-1:0]  alu_in1,
  output logic [XLEN-1:0]  alu_in2,
  output logic [3:0]       alu_sel,
  output logic             is_branch,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [3:0] dec_sel;
  logic       dec_use_imm;
  logic       dec_br;
  logic       dec_ne;
  logic       dec_ill;

  alu_op_decode u_dec (
    .instr     (instr),
    .sel       (dec_sel),
    .use_imm   (dec_use_imm),
    .is_branch (dec_br),
    .branch_ne (dec_ne),
    .illegal   (dec_ill)
  );

  issue_t nxt;
  issue_t main_q;
  issue_t skid_q;
  logic   main_v;
  logic   skid_v;
  logic   accept;
  logic   drain;

  always_comb begin
    nxt           = '0;
    nxt.sel       = dec_sel;
    nxt.is_branch = dec_br;
    nxt.branch_ne = dec_ne;
    nxt.illegal   = dec_ill;
    if (!dec_ill) begin
      nxt.in1 = rs1_data;
      nxt.in2 = dec_use_imm ? imm : rs2_data;
    end
  end

  assign s_ready = !skid_v;
  assign m_valid = main_v;
  assign accept  = s_valid && s_ready;
  assign drain   = main_v && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q      <= '0;
      skid_q      <= '0;
      main_v      <= 1'b0;
      skid_v      <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (!main_v || drain) begin
        // Skid is older than anything arriving now.
        if (skid_v) begin
          main_q <= skid_q;
          main_v <= 1'b1;
          skid_v <= 1'b0;
        end else if (accept) begin
          main_q <= nxt;
          main_v <= 1'b1;
        end else begin
          main_v <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= nxt;
        skid_v <= 1'b1;
      end
      if (accept && nxt.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

  assign alu_in1   = main_q.in1;
  assign alu_in2   = main_q.in2;
  assign alu_sel   = main_q.sel;
  assign is_branch = main_q.is_branch;
  assign branch_ne = main_q.branch_ne;
  assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized self-checking bench for alu_issue_stage.
// Queue-based reference model plus directed scenarios.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  sel;
    logic        br;
    logic        ne;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [3:0]  alu_sel;
  logic        is_branch;
  logic        branch_ne;
  logic        illegal;
  logic [15:0] illegal_cnt;

  logic        s2_valid;
  logic        s2_ready;
  logic        s2_mvalid;
  logic [31:0] s2_in1;
  logic [31:0] s2_in2;
  logic [3:0]  s2_sel;
  logic        s2_br;
  logic        s2_ne;
  logic        s2_ill;
  logic [2:0]  s2_cnt;

  int   checks = 0;
  int   fails  = 0;
  exp_t mq[$];
  int   mcnt   = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .instr(instr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm(imm),
    .m_valid(m_valid), .m_ready(m_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_sel(alu_sel), .is_branch(is_branch),
    .branch_ne(branch_ne), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst),
    .s_valid(s2_valid), .s_ready(s2_ready),
    .instr(32'h0000007F), .rs1_data(32'h1),
    .rs2_data(32'h2), .imm(32'h3),
    .m_valid(s2_mvalid), .m_ready(1'b1),
    .alu_in1(s2_in1), .alu_in2(s2_in2),
    .alu_sel(s2_sel), .is_branch(s2_br),
    .branch_ne(s2_ne), .illegal(s2_ill),
    .illegal_cnt(s2_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decode written straight from the instruction table.
  function automatic exp_t ref_dec(input logic [31:0] ins,
                                   input logic [31:0] r1,
                                   input logic [31:0] r2,
                                   input logic [31:0] im);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    op = ins[6:0];
    f3 = ins[14:12];
    e = '0;
    e.ill = 1'b1;
    if (op == 7'h33 && f3 == 3'd0) begin
      e.sel = ins[30] ? 4'd6 : 4'd2; e.ill = 0;
    end else if (op == 7'h33 && f3 == 3'd7) begin
      e.sel = 4'd0; e.ill = 0;
    end else if (op == 7'h33 && f3 == 3'd6) begin
      e.sel = 4'd1; e.ill = 0;
    end else if (op == 7'h13 && f3 == 3'd0) begin
      e.sel = 4'd2; e.ill = 0;
    end else if (op == 7'h13 && f3 == 3'd7) begin
      e.sel = 4'd0; e.ill = 0;
    end else if (op == 7'h13 && f3 == 3'd6) begin
      e.sel = 4'd1; e.ill = 0;
    end else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) begin
      e.sel = 4'd6; e.ill = 0; e.br = 1; e.ne = (f3 == 3'd1);
    end else if (op == 7'h03 || op == 7'h23) begin
      e.sel = 4'd2; e.ill = 0;
    end
    if (!e.ill) begin
      e.in1 = r1;
      e.in2 = (op == 7'h13 || op == 7'h03 || op == 7'h23) ? im : r2;
    end
    return e;
  endfunction

  task automatic check_all();
    chk("s_ready", s_ready, mq.size() < 2);
    chk("m_valid", m_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("alu_in1", alu_in1, mq[0].in1);
      chk("alu_in2", alu_in2, mq[0].in2);
      chk("alu_sel", alu_sel, mq[0].sel);
      chk("is_branch", is_branch, mq[0].br);
      chk("branch_ne", branch_ne, mq[0].ne);
      chk("illegal", illegal, mq[0].ill);
    end
    chk("illegal_cnt", illegal_cnt, mcnt);
  endtask

  // Drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input logic sv, input logic [31:0] ins,
                     input logic [31:0] r1, input logic [31:0] r2,
                     input logic [31:0] im, input logic mr);
    bit   acc;
    bit   drn;
    exp_t e;
    s_valid  = sv;
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    imm      = im;
    m_ready  = mr;
    @(posedge clk);
    acc = sv && (mq.size() < 2);
    drn = mr && (mq.size() > 0);
    e   = ref_dec(ins, r1, r2, im);
    if (drn) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(e);
      if (e.ill && mcnt < 65535) mcnt++;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [6];
    logic [31:0] w;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h63;
    ops[3] = 7'h03; ops[4] = 7'h23;
    ops[5] = 7'($urandom);
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 5)];
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    s_valid = 0; instr = 0; rs1_data = 0;
    rs2_data = 0; imm = 0; m_ready = 0;
    s2_valid = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_cnt", illegal_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // R-type SUB
    cyc(1, 32'h40208033, 7, 5, 0, 1);
    chk("sub_sel", alu_sel, 6);
    chk("sub_in2", alu_in2, 5);
    idle(1);

    // ADDI, ANDI, ORI back to back
    cyc(1, 32'h00A08093, 3, 99, 10, 1);
    chk("addi_sel", alu_sel, 2);
    cyc(1, 32'h00A0F093, 3, 99, 11, 1);
    chk("andi_sel", alu_sel, 0);
    chk("andi_rdy", s_ready, 1);
    cyc(1, 32'h00A0E093, 3, 99, 12, 1);
    chk("ori_sel", alu_sel, 1);
    chk("ori_in2", alu_in2, 12);
    idle(1);

    // Branches
    cyc(1, 32'h00209463, 8, 9, 0, 1);
    chk("bne_br", is_branch, 1);
    chk("bne_ne", branch_ne, 1);
    cyc(1, 32'h00208463, 8, 9, 0, 1);
    chk("beq_ne", branch_ne, 0);
    idle(1);

    // Illegal x3
    for (int i = 0; i < 3; i++) cyc(1, 32'h0000007F, 5, 6, 7, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_cnt3", illegal_cnt, 3);
    idle(1);

    // Backpressure: third instruction must stall
    cyc(1, 32'h00A08093, 1, 2, 21, 0);
    cyc(1, 32'h00A0F093, 1, 2, 22, 0);
    cyc(1, 32'h00A0E093, 1, 2, 23, 0);
    chk("bp_full", s_ready, 0);
    cyc(1, 32'h00A0E093, 1, 2, 23, 0);
    chk("bp_hold", alu_in2, 21);
    cyc(1, 32'h00A0E093, 1, 2, 23, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle(2);

    // Random traffic with random backpressure
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 9) < 7, rnd_instr(), $urandom,
          $urandom, $urandom, $urandom_range(0, 9) < 6);
    idle(3);

    // Async reset with both entries full
    cyc(1, 32'h00A08093, 4, 5, 6, 0);
    cyc(1, 32'h40208033, 4, 5, 6, 0);
    chk("pre_rst_full", s_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_in1", alu_in1, 0);
    chk("arst_in2", alu_in2, 0);
    chk("arst_sel", alu_sel, 0);
    chk("arst_flags", {is_branch, branch_ne, illegal}, 0);
    chk("arst_cnt", illegal_cnt, 0);
    mq.delete();
    mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    s_valid = 0;
    @(negedge clk);
    chk("post_rst_rdy", s_ready, 1);
    check_all();

    // Counter saturation on a narrow instance
    s2_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("sat_cnt", s2_cnt, (k < 7) ? k : 7);
    end
    chk("sat_ill", s2_ill, 1);
    chk("sat_sel", s2_sel, 0);
    s2_valid = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
